alu_req_arbiter: RTL and testbench

- Shares one add_sub unit between two requesters.
- Each requester issues an operation {A, B, OP} through a valid/ready handshake.
- The block grants requesters round-robin, holds the latched operands stable on the unit for a settle window, then registers R/SF/ZF/DZF into a single response channel tagged with the requester id.
- Sits between instruction sources (e.g. control unit and test/debug port) and the arithmetic datapath.

---
 rtl/alu_pkg.sv | 17 +
 rtl/add_sub.sv | 38 +++
 rtl/alu_req_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: FSM encoding,
// opcode values and operand/result widths.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int OPND_W = 3;
  localparam int RES_W  = 4;

endpackage

// File: rtl/add_sub.sv
// Sign-magnitude 3-bit adder/subtractor producing a 4-bit sign-magnitude result.
// DZF flags a zero-magnitude B operand (either sign) for the downstream divide path.
module add_sub
  import alu_pkg::*;
(
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic              OP,
  output logic [RES_W-1:0]  R,
  output logic              SF,
  output logic              ZF,
  output logic              DZF
);

  function automatic logic signed [4:0] sm_to_int(input logic [OPND_W-1:0] v);
    logic signed [4:0] m;
    m = {3'b000, v[1:0]};
    return v[2] ? -m : m;
  endfunction

  logic signed [4:0] a_s;
  logic signed [4:0] b_s;
  logic signed [4:0] sum_s;
  logic signed [4:0] mag_s;

  always_comb begin
    a_s   = sm_to_int(A);
    b_s   = sm_to_int(B);
    sum_s = (OP == OP_SUB) ? (a_s - b_s) : (a_s + b_s);
    mag_s = sum_s[4] ? -sum_s : sum_s;
    // A zero sum is always reported as positive zero.
    R     = {sum_s[4], mag_s[2:0]};
    SF    = sum_s[4];
    ZF    = (mag_s == 5'sd0);
    DZF   = (B[1:0] == 2'b00);
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one add_sub between two valid/ready requesters,
// with a settle window on latched operands and a single tagged response channel.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_a,
  input  logic [2:0]       req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_a,
  input  logic [2:0]       req1_b,
  input  logic             req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [3:0]       resp_r,
  output logic             resp_sf,
  output logic             resp_zf,
  output logic             resp_dzf,
  output logic [CNT_W-1:0] done_count
);

  localparam int SET_W = 4;

  state_e              state_q;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;
  logic                op_q;
  logic                id_q;
  logic                last_grant_q;
  logic [SET_W-1:0]    cnt_q;
  logic                resp_valid_q;
  logic                resp_id_q;
  logic [RES_W-1:0]    resp_r_q;
  logic                resp_sf_q;
  logic                resp_zf_q;
  logic                resp_dzf_q;
  logic [CNT_W-1:0]    done_q;

  logic                gnt_vld;
  logic                gnt_id;
  logic [RES_W-1:0]    as_r;
  logic                as_sf;
  logic                as_zf;
  logic                as_dzf;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready = ~rst & (state_q == IDLE) & gnt_vld & ~gnt_id;
  assign req1_ready = ~rst & (state_q == IDLE) & gnt_vld &  gnt_id;

  add_sub u_add_sub (
    .A   (a_q),
    .B   (b_q),
    .OP  (op_q),
    .R   (as_r),
    .SF  (as_sf),
    .ZF  (as_zf),
    .DZF (as_dzf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_r_q     <= '0;
      resp_sf_q    <= 1'b0;
      resp_zf_q    <= 1'b0;
      resp_dzf_q   <= 1'b0;
      done_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            a_q          <= gnt_id ? req1_a  : req0_a;
            b_q          <= gnt_id ? req1_b  : req0_b;
            op_q         <= gnt_id ? req1_op : req0_op;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            cnt_q        <= SET_W'(SETTLE_CYCLES - 1);
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_r_q     <= as_r;
            resp_sf_q    <= as_sf;
            resp_zf_q    <= as_zf;
            resp_dzf_q   <= as_dzf;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            done_q       <= done_q + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_r     = resp_r_q;
  assign resp_sf    = resp_sf_q;
  assign resp_zf    = resp_zf_q;
  assign resp_dzf   = resp_dzf_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter (SETTLE_CYCLES=1, CNT_W=2).
module tb_alu_req_arbiter;

  localparam int SETTLE = 1;
  localparam int CW     = 2;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req0_op;
  logic [2:0]    req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_op;
  logic [2:0]    req1_a, req1_b;
  logic          resp_valid, resp_ready, resp_id;
  logic [3:0]    resp_r;
  logic          resp_sf, resp_zf, resp_dzf;
  logic [CW-1:0] done_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  alu_req_arbiter #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_r     (resp_r),
    .resp_sf    (resp_sf),
    .resp_zf    (resp_zf),
    .resp_dzf   (resp_dzf),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a single requester, check latency and flags,
  // and optionally accept the response. Entered and left on a negedge.
  task automatic do_op(input string tag, input logic id, input logic [2:0] a,
                       input logic [2:0] b, input logic op, input logic [3:0] er,
                       input logic esf, input logic ezf, input logic edz,
                       input logic accept);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk({tag, "_ready"},  id ? req1_ready : req0_ready, 1'b1);
    chk({tag, "_oready"}, id ? req0_ready : req1_ready, 1'b0);
    @(negedge clk);
    // Operands change after the handshake and must be ignored.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 3'b111; req0_b = 3'b111; req0_op = ~req0_op;
    req1_a = 3'b111; req1_b = 3'b111; req1_op = ~req1_op;
    chk({tag, "_exec_valid"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_id"},    resp_id,    id);
    chk({tag, "_r"},     resp_r,     er);
    chk({tag, "_sf"},    resp_sf,    esf);
    chk({tag, "_zf"},    resp_zf,    ezf);
    chk({tag, "_dzf"},   resp_dzf,   edz);
    if (accept) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 4;
      chk({tag, "_done_valid"}, resp_valid, 1'b0);
      chk({tag, "_done_count"}, done_count, exp_cnt);
    end
  endtask

  initial begin
    int seen;
    int cyc;
    int last;

    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 3'b001; req0_b = 3'b001; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 3'b001; req1_b = 3'b001; req1_op = 1'b0;
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready0_late", req0_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_id",    resp_id,    1'b0);
    chk("rst_r",     resp_r,     4'b0000);
    chk("rst_flags", {resp_sf, resp_zf, resp_dzf}, 3'b000);
    chk("rst_done",  done_count, 0);

    // Reset while the operation is in EXEC drops it with no response.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 3'b001; req0_b = 3'b001; req0_op = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 1'b0);
    chk("midrst_done",  done_count, 0);
    repeat (3) @(negedge clk);
    chk("midrst_noresp", resp_valid, 1'b0);

    do_op("add",    1'b0, 3'b001, 3'b010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("zero",   1'b1, 3'b011, 3'b011, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op("neg",    1'b0, 3'b010, 3'b011, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op("negzero",1'b1, 3'b100, 3'b100, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);

    // Backpressure: -1 + 2 = +1 held for 5 cycles with both requesters waiting.
    do_op("bp", 1'b1, 3'b101, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid",  resp_valid, 1'b1);
      chk("bp_stable", {resp_id, resp_r, resp_sf, resp_zf, resp_dzf}, {1'b1, 4'b0001, 3'b000});
      chk("bp_readies", {req0_ready, req1_ready}, 2'b00);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 4;
    chk("bp_released", resp_valid, 1'b0);
    chk("wrap_done",   done_count, 1);

    // Contention: req0 3+1=+4, req1 1-(-2)=+3; grants must alternate from req0.
    req0_a = 3'b011; req0_b = 3'b001; req0_op = 1'b0;
    req1_a = 3'b001; req1_b = 3'b110; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    #1;
    chk("cont_first_grant", {req0_ready, req1_ready}, 2'b10);
    seen = 0; cyc = 0; last = 0;
    while (seen < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        chk("cont_id", resp_id, seen % 2);
        chk("cont_r",  resp_r,  (seen % 2) ? 4'b0011 : 4'b0100);
        if (seen > 0) chk("cont_gap", cyc - last, SETTLE + 2);
        last = cyc;
        seen++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_count", seen, 6);
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = (exp_cnt + 6) % 4;
    chk("cont_done", done_count, exp_cnt);
    chk("cont_idle", resp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
